// File: rtl/cond_exec_stage_pkg.sv
// rtl/cond_exec_stage_pkg.sv - condition codes, flag indices and E-stage control record
package cond_exec_stage_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [3:0] cond;
        logic       pcsrc;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic [3:0] alu_control;
        logic [1:0] flag_write;
    } ex_ctrl_t;

    // A bubble is an always-executing no-op so CondExE reads 1 while idle.
    localparam ex_ctrl_t BUBBLE_CTRL = '{
        cond:        COND_AL,
        pcsrc:       1'b0,
        branch:      1'b0,
        regwrite:    1'b0,
        memwrite:    1'b0,
        memtoreg:    1'b0,
        alusrc:      1'b0,
        alu_control: 4'b0000,
        flag_write:  2'b00
    };

endpackage

// File: rtl/cond_exec_stage_if.sv
// rtl/cond_exec_stage_if.sv - decode/hazard inputs and execute-stage outputs
interface cond_exec_stage_if;
    logic       StallE;
    logic       FlushE;
    logic [3:0] CondD;
    logic       PCSrcD;
    logic       BranchD;
    logic       RegWriteD;
    logic       MemWriteD;
    logic       MemtoRegD;
    logic       AluSrcD;
    logic [3:0] AluControlD;
    logic [1:0] FlagWriteD;
    logic [3:0] ALUFlags;

    logic       PCSrcE;
    logic       BranchTakenE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       MemtoRegE;
    logic       AluSrcE;
    logic [3:0] AluControlE;
    logic       CondExE;
    logic [3:0] Flags;

    modport master (
        output StallE, FlushE, CondD, PCSrcD, BranchD, RegWriteD, MemWriteD,
               MemtoRegD, AluSrcD, AluControlD, FlagWriteD, ALUFlags,
        input  PCSrcE, BranchTakenE, RegWriteE, MemWriteE, MemtoRegE,
               AluSrcE, AluControlE, CondExE, Flags
    );

    modport slave (
        input  StallE, FlushE, CondD, PCSrcD, BranchD, RegWriteD, MemWriteD,
               MemtoRegD, AluSrcD, AluControlD, FlagWriteD, ALUFlags,
        output PCSrcE, BranchTakenE, RegWriteE, MemWriteE, MemtoRegE,
               AluSrcE, AluControlE, CondExE, Flags
    );
endinterface

// File: rtl/cond_exec_stage_cond_check.sv
// rtl/cond_exec_stage_cond_check.sv - combinational condition-field evaluation against NZCV
module cond_check
    import cond_exec_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - D/E pipeline register, NZCV register and condition-gated controls
module cond_exec_stage
    import cond_exec_stage_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    cond_exec_stage_if.slave bus
);
    ex_ctrl_t   ctrl_d;
    ex_ctrl_t   ctrl_e;
    logic [3:0] flags_q;
    logic       cond_ex;
    logic       flag_commit;

    assign ctrl_d = '{
        cond:        bus.CondD,
        pcsrc:       bus.PCSrcD,
        branch:      bus.BranchD,
        regwrite:    bus.RegWriteD,
        memwrite:    bus.MemWriteD,
        memtoreg:    bus.MemtoRegD,
        alusrc:      bus.AluSrcD,
        alu_control: bus.AluControlD,
        flag_write:  bus.FlagWriteD
    };

    cond_check u_cond_check (
        .cond    (ctrl_e.cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // Flush overrides stall, so the instruction leaving E still retires its flags.
    assign flag_commit = cond_ex & (~bus.StallE | bus.FlushE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_e  <= BUBBLE_CTRL;
            flags_q <= 4'b0000;
        end else begin
            if (flag_commit && ctrl_e.flag_write[1]) begin
                flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
            end
            if (flag_commit && ctrl_e.flag_write[0]) begin
                flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
            end
            if (bus.FlushE) begin
                ctrl_e <= BUBBLE_CTRL;
            end else if (!bus.StallE) begin
                ctrl_e <= ctrl_d;
            end
        end
    end

    assign bus.PCSrcE       = ctrl_e.pcsrc & cond_ex;
    assign bus.BranchTakenE = ctrl_e.branch & cond_ex;
    assign bus.RegWriteE    = ctrl_e.regwrite & cond_ex;
    assign bus.MemWriteE    = ctrl_e.memwrite & cond_ex;
    assign bus.MemtoRegE    = ctrl_e.memtoreg;
    assign bus.AluSrcE      = ctrl_e.alusrc;
    assign bus.AluControlE  = ctrl_e.alu_control;
    assign bus.CondExE      = cond_ex;
    assign bus.Flags        = flags_q;
endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - directed vector table plus randomized run against a reference model
module tb_cond_exec_stage;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    cond_exec_stage_if bus ();

    cond_exec_stage dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] cond;
        logic       pc;
        logic       br;
        logic       rw;
        logic       mw;
        logic       mr;
        logic       as;
        logic [3:0] ac;
        logic [1:0] fw;
    } instr_t;

    // inputs: {rst,stall,flush, cond, pc,br,rw,mw, fw, alf}; exp: {PCSrcE,BranchTakenE,RegWriteE,MemWriteE,CondExE,Flags}
    typedef struct {
        logic [16:0] in;
        logic [8:0]  exp;
    } vec_t;

    instr_t     m_e;
    logic [3:0] m_flags;
    instr_t     nop_instr;

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cc;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cc && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic instr_t cur_input();
        instr_t r;
        r.cond = bus.CondD;  r.pc = bus.PCSrcD;   r.br = bus.BranchD;
        r.rw = bus.RegWriteD; r.mw = bus.MemWriteD; r.mr = bus.MemtoRegD;
        r.as = bus.AluSrcD;  r.ac = bus.AluControlD; r.fw = bus.FlagWriteD;
        return r;
    endfunction

    task automatic model_update();
        logic ok;
        if (RESET) begin
            m_e = nop_instr;
            m_flags = 4'b0000;
        end else begin
            ok = ref_cond(m_e.cond, m_flags);
            if (ok && (!bus.StallE || bus.FlushE)) begin
                if (m_e.fw[1]) m_flags[3:2] = bus.ALUFlags[3:2];
                if (m_e.fw[0]) m_flags[1:0] = bus.ALUFlags[1:0];
            end
            if (bus.FlushE) m_e = nop_instr;
            else if (!bus.StallE) m_e = cur_input();
        end
    endtask

    function automatic logic [14:0] model_vec();
        logic c;
        c = ref_cond(m_e.cond, m_flags);
        return {m_e.pc & c, m_e.br & c, m_e.rw & c, m_e.mw & c,
                m_e.mr, m_e.as, m_e.ac, c, m_flags};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.PCSrcE, bus.BranchTakenE, bus.RegWriteE, bus.MemWriteE,
                bus.MemtoRegE, bus.AluSrcE, bus.AluControlE, bus.CondExE, bus.Flags};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic randomize_inputs();
        bus.CondD       = 4'($urandom);
        bus.PCSrcD      = 1'($urandom);
        bus.BranchD     = 1'($urandom);
        bus.RegWriteD   = 1'($urandom);
        bus.MemWriteD   = 1'($urandom);
        bus.MemtoRegD   = 1'($urandom);
        bus.AluSrcD     = 1'($urandom);
        bus.AluControlD = 4'($urandom);
        bus.FlagWriteD  = 2'($urandom);
        bus.ALUFlags    = 4'($urandom);
    endtask

    vec_t tbl[23];

    initial begin
        total = 0;
        bad = 0;
        nop_instr = '{cond: 4'b1110, default: '0};
        m_e = nop_instr;
        m_flags = 4'b0000;

        tbl[0]  = '{{3'b100, 4'b0000, 4'b1111, 2'b11, 4'b1111}, 9'b0000_1_0000};
        tbl[1]  = '{{3'b100, 4'b0000, 4'b1111, 2'b11, 4'b1111}, 9'b0000_1_0000};
        tbl[2]  = '{{3'b000, 4'b1110, 4'b0010, 2'b11, 4'b0100}, 9'b0010_1_0000};
        tbl[3]  = '{{3'b000, 4'b0000, 4'b1100, 2'b00, 4'b0100}, 9'b1100_1_0100};
        tbl[4]  = '{{3'b000, 4'b0001, 4'b1100, 2'b00, 4'b0000}, 9'b0000_0_0100};
        tbl[5]  = '{{3'b000, 4'b1110, 4'b0000, 2'b10, 4'b0000}, 9'b0000_1_0100};
        tbl[6]  = '{{3'b000, 4'b1110, 4'b0000, 2'b01, 4'b1011}, 9'b0000_1_1000};
        tbl[7]  = '{{3'b000, 4'b1011, 4'b0010, 2'b11, 4'b0111}, 9'b0000_0_1011};
        tbl[8]  = '{{3'b000, 4'b1110, 4'b0000, 2'b00, 4'b0000}, 9'b0000_1_1011};
        tbl[9]  = '{{3'b000, 4'b1110, 4'b0000, 2'b01, 4'b0000}, 9'b0000_1_1011};
        tbl[10] = '{{3'b000, 4'b1011, 4'b0010, 2'b00, 4'b1010}, 9'b0010_1_1010};
        tbl[11] = '{{3'b000, 4'b1110, 4'b0010, 2'b11, 4'b0000}, 9'b0010_1_1010};
        tbl[12] = '{{3'b010, 4'b0000, 4'b1100, 2'b00, 4'b0101}, 9'b0010_1_1010};
        tbl[13] = '{{3'b010, 4'b0000, 4'b1100, 2'b00, 4'b0101}, 9'b0010_1_1010};
        tbl[14] = '{{3'b010, 4'b0000, 4'b1100, 2'b00, 4'b0101}, 9'b0010_1_1010};
        tbl[15] = '{{3'b000, 4'b0000, 4'b1100, 2'b00, 4'b0101}, 9'b1100_1_0101};
        tbl[16] = '{{3'b000, 4'b1110, 4'b0001, 2'b11, 4'b0000}, 9'b0001_1_0101};
        tbl[17] = '{{3'b011, 4'b0000, 4'b1010, 2'b00, 4'b1000}, 9'b0000_1_1000};
        tbl[18] = '{{3'b000, 4'b1111, 4'b1111, 2'b11, 4'b0000}, 9'b0000_0_1000};
        tbl[19] = '{{3'b000, 4'b1110, 4'b0010, 2'b11, 4'b0111}, 9'b0010_1_1000};
        tbl[20] = '{{3'b100, 4'b1110, 4'b1111, 2'b11, 4'b0111}, 9'b0000_1_0000};
        tbl[21] = '{{3'b000, 4'b1110, 4'b0010, 2'b11, 4'b0000}, 9'b0010_1_0000};
        tbl[22] = '{{3'b001, 4'b1110, 4'b1111, 2'b11, 4'b1100}, 9'b0000_1_1100};

        RESET = 1'b1;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        randomize_inputs();

        for (int i = 0; i < 23; i++) begin
            randomize_inputs();
            {RESET, bus.StallE, bus.FlushE} = tbl[i].in[16:14];
            bus.CondD = tbl[i].in[13:10];
            {bus.PCSrcD, bus.BranchD, bus.RegWriteD, bus.MemWriteD} = tbl[i].in[9:6];
            bus.FlagWriteD = tbl[i].in[5:4];
            bus.ALUFlags = tbl[i].in[3:0];
            cycle();
            check($sformatf("vec%0d", i),
                  {6'b0, bus.PCSrcE, bus.BranchTakenE, bus.RegWriteE, bus.MemWriteE,
                   bus.CondExE, bus.Flags},
                  {6'b0, tbl[i].exp});
        end

        RESET = 1'b1;
        randomize_inputs();
        cycle();
        check("reset_full", dut_vec(), 15'b000000_0000_1_0000);

        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            RESET      = ($urandom_range(0, 39) == 0);
            bus.StallE = ($urandom_range(0, 3) == 0);
            bus.FlushE = ($urandom_range(0, 7) == 0);
            cycle();
            check($sformatf("rand%0d", i), dut_vec(), model_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Decode-to-execute boundary of the pipelined processor. Registers the decode-stage control word produced by the instruction controller, holds the architectural NZCV flag register, evaluates the instruction's condition field against those flags, and emits condition-gated execute-stage control (PCSrcE, RegWriteE, MemWriteE, BranchTakenE). Supports stall and flush from the hazard unit.

## Interface
- No parameters; all widths are fixed by the ISA.
- Clock: CLK; reset: RESET. One clock; reset is synchronous and active-high.
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- StallE  in  1  hold execute-stage registers and flags.
- FlushE  in  1  load a bubble into execute stage.
- CondD  in  4  Instruction[31:28] of the decode-stage instruction.
- PCSrcD, BranchD, RegWriteD, MemWriteD, MemtoRegD, AluSrcD  in  1 each  decode control bits.
- AluControlD  in  4  ALU operation.
- FlagWriteD  in  2  bit1 = write N,Z; bit0 = write C,V.
- ALUFlags  in  4  NZCV from the execute-stage ALU (bit3 N, bit2 Z, bit1 C, bit0 V).
- PCSrcE, BranchTakenE, RegWriteE, MemWriteE  out  1 each  condition-gated controls.
- MemtoRegE, AluSrcE  out  1 each  registered, ungated.
- AluControlE  out  4  registered, ungated.
- CondExE  out  1  condition of instruction in E passes.
- Flags  out  4  current NZCV register.

## Operation
- Pipeline register: on each rising CLK, if not stalled, capture CondD and all D controls into E registers.
- CondExE evaluated combinationally from CondE and the current Flags (pre-update values): EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; 1111 is reserved and evaluates to 0.
- Gated outputs: PCSrcE = PCSrcE_q&CondExE; BranchTakenE = BranchE_q&CondExE; RegWriteE = RegWriteE_q&CondExE; MemWriteE = MemWriteE_q&CondExE.
- Flag update at CLK edge when CondExE & !StallE & !RESET: if FlagWriteE[1], N,Z <- ALUFlags[3:2]; if FlagWriteE[0], C,V <- ALUFlags[1:0]. Halves are independent.
- Bubble: all E control bits 0, AluControlE 0000, CondE 1110.

## Timing
- Latency: D inputs appear at E outputs one cycle later; flags written by instruction i are visible to instruction i+1's condition evaluation in the next cycle (no bypass needed).
- Reset: all E control registers 0, AluControlE 0000, CondE 1110, Flags 0000; thus all outputs 0 except CondExE = 1.
- Priority per edge: RESET > FlushE > StallE > normal load.
- FlushE and StallE together: flush wins; E becomes bubble. Flags still updated by the instruction leaving E if CondExE (flush discards the incoming instruction, not the one completing).
- StallE alone: E registers and Flags hold; outputs stay stable.
- Failed condition: no register write, memory write, branch or flag update; MemtoRegE/AluControlE still reflect the instruction (harmless).
- RESET mid-stream: discards E instruction, no flag update that cycle.

## Structure
- Shared package: condition-code constants (COND_EQ..COND_AL, COND_NV), flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), bubble control constants.
- One sub-module: cond_check (combinational CondE + Flags -> CondExE), reused by any later predicated stage.

## Test plan
- Reset: assert RESET 2 cycles with random D inputs -> all gated outputs 0, Flags 0000, CondExE 1.
- SUBS with AL, FlagWriteD 11, ALUFlags 0100 -> next edge Flags 0100; following BEQ (CondD 0000, PCSrcD 1) -> PCSrcE 1, BranchTakenE 1; BNE (0001) -> PCSrcE 0.
- FlagWriteD 10, ALUFlags 1011 with Flags 0000 -> Flags 1000 (C,V unchanged); FlagWriteD 01 then ALUFlags 0111 -> Flags 1011.
- Conditional ADD, CondD 1011 (LT), Flags N=1 V=0 -> RegWriteE 1; Flags N=1 V=1 -> RegWriteE 0, no flag update even with FlagWriteD 11.
- StallE 1 for 3 cycles during flag-setting instruction -> E outputs and Flags constant; update occurs on first unstalled edge only.
- FlushE and StallE both 1 -> E becomes bubble (all gated outputs 0, CondE 1110); CondD 1111 after flush -> CondExE 0.
